// File: rtl/dac_rd_pkg.sv
// Shared types and helpers for the DAC playback read master (dac_mem_reader).
// Optional looped playback is enabled with the DAC_LOOP_PLAY_EN macro.
package dac_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ABORT = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         BOUNDARY_4K   = 4096;

    function automatic int bpb(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dac_rd_fifo.sv
// Synchronous read-data FIFO for dac_mem_reader: head entry is visible combinationally,
// with an occupancy count and a synchronous flush that empties it in one cycle.
module dac_rd_fifo
    import dac_rd_pkg::*;
#(
    parameter int WIDTH = 129,
    parameter int DEPTH = 64,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/dac_mem_reader.sv
// AXI4 read master replaying a memory buffer onto an AXI4-Stream toward the DAC path.
// Define DAC_LOOP_PLAY_EN to add the loop_en input for continuous multi-pass playback.
module dac_mem_reader
    import dac_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  ps_clk,
    input  logic                  ps_rstb,
    input  logic                  play_start,
    input  logic                  play_reset,
`ifdef DAC_LOOP_PLAY_EN
    input  logic                  loop_en,
`endif
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [31:0]           play_size,
    output logic [3:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  m_axi_awvalid,
    output logic                  m_axi_wvalid,
    output logic                  m_axi_bready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  play_done,
    output logic                  rd_err,
    output logic [31:0]           run_cycles,
    output logic [31:0]           beats_sent
);

    localparam int BPB     = bpb(DATA_WIDTH);
    localparam int LOG_BPB = clog2(BPB);
    localparam int CW      = clog2(FIFO_DEPTH) + 1;

    rd_state_t             r_state;
    logic                  r_start_d;
    logic [31:0]           r_total;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [31:0]           r_ar_left;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [CW-1:0]         r_outstanding;
    logic [31:0]           r_rx_cnt;
    logic [31:0]           r_beats_sent;
    logic [31:0]           r_run_cycles;
    logic                  r_done;
    logic                  r_err;
    logic                  r_loop_pend;

    logic                  w_start_edge;
    logic                  w_loop_req;
    logic [31:0]           w_total_beats;
    logic [ADDR_WIDTH-1:0] w_start_aligned;
    logic [31:0]           w_to_4k;
    logic [31:0]           w_burst;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_reload;
    logic                  w_ar_hs;
    logic                  w_rready;
    logic                  w_r_hs;
    logic                  w_push;
    logic                  w_push_last;
    logic                  w_tvalid;
    logic                  w_pop;
    logic                  w_pop_last;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic [DATA_WIDTH:0]   w_fifo_dout;

`ifdef DAC_LOOP_PLAY_EN
    assign w_loop_req = loop_en;
`else
    assign w_loop_req = 1'b0;
`endif

    assign w_start_edge    = play_start && !r_start_d;
    assign w_total_beats   = play_size >> LOG_BPB;
    assign w_start_aligned = start_address & ~ADDR_WIDTH'(BPB - 1);

    // Burst length is capped by the burst limit, the beats left and the next 4KB boundary.
    always_comb begin
        w_to_4k = (32'(BOUNDARY_4K) - {20'd0, r_next_addr[11:0]}) >> LOG_BPB;
        w_burst = 32'(BURST_LEN);
        if (r_ar_left < w_burst) begin
            w_burst = r_ar_left;
        end
        if (w_to_4k < w_burst) begin
            w_burst = w_to_4k;
        end
    end

    // Space is reserved for every requested beat, so R data never needs back-pressure.
    assign w_credit_ok = (32'(w_fifo_count) + 32'(r_outstanding) + w_burst) <= 32'(FIFO_DEPTH);
    assign w_issue     = (r_state == RUN) && !r_arvalid && (r_ar_left != 32'd0) && w_credit_ok;
    assign w_ar_hs     = r_arvalid && m_axi_arready;
    assign w_rready    = (r_state == RUN) || (r_state == ABORT);
    assign w_r_hs      = m_axi_rvalid && w_rready;
    assign w_push      = w_r_hs && (r_state == RUN);
    assign w_push_last = (r_rx_cnt == r_total - 32'd1);
    assign w_tvalid    = (r_state == RUN) && !w_fifo_empty;
    assign w_pop       = w_tvalid && m_axis_tready;
    assign w_pop_last  = w_pop && w_fifo_dout[DATA_WIDTH];
    assign w_reload    = w_loop_req && !r_arvalid && (r_ar_left == 32'd0) && !r_loop_pend && !w_pop_last;

    dac_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ps_clk),
        .rst_n   (ps_rstb),
        .i_flush (r_state == ABORT),
        .i_push  (w_push),
        .i_data  ({w_push_last, m_axi_rdata}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            r_state       <= IDLE;
            r_start_d     <= 1'b0;
            r_total       <= '0;
            r_base        <= '0;
            r_next_addr   <= '0;
            r_ar_left     <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_outstanding <= '0;
            r_rx_cnt      <= '0;
            r_beats_sent  <= '0;
            r_run_cycles  <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_loop_pend   <= 1'b0;
        end else begin
            r_start_d     <= play_start;
            r_outstanding <= r_outstanding
                           + (w_ar_hs ? CW'(r_arlen) + CW'(1) : CW'(0))
                           - (w_r_hs ? CW'(1) : CW'(0));
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end
            if (w_push) begin
                r_rx_cnt <= w_push_last ? 32'd0 : r_rx_cnt + 32'd1;
                if (m_axi_rresp != AXI_RESP_OKAY) begin
                    r_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_beats_sent <= r_beats_sent + 32'd1;
            end
            if (r_state == RUN && r_run_cycles != '1) begin
                r_run_cycles <= r_run_cycles + 32'd1;
            end

            case (r_state)
                IDLE, DONE: begin
                    if (play_reset) begin
                        r_state <= ABORT;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end else if (w_start_edge) begin
                        r_total      <= w_total_beats;
                        r_base       <= w_start_aligned;
                        r_next_addr  <= w_start_aligned;
                        r_ar_left    <= w_total_beats;
                        r_rx_cnt     <= '0;
                        r_beats_sent <= '0;
                        r_run_cycles <= '0;
                        r_err        <= 1'b0;
                        r_loop_pend  <= 1'b0;
                        r_done       <= (w_total_beats == 32'd0);
                        r_state      <= (w_total_beats == 32'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (play_reset) begin
                        r_state     <= ABORT;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_loop_pend <= 1'b0;
                    end else begin
                        if (w_issue) begin
                            r_arvalid   <= 1'b1;
                            r_araddr    <= r_next_addr;
                            r_arlen     <= 8'(w_burst - 32'd1);
                            r_next_addr <= r_next_addr + ADDR_WIDTH'(w_burst << LOG_BPB);
                            r_ar_left   <= r_ar_left - w_burst;
                        end else if (w_reload) begin
                            // Prefetch the next pass so the stream runs without a gap.
                            r_ar_left   <= r_total;
                            r_next_addr <= r_base;
                            r_loop_pend <= 1'b1;
                        end
                        if (w_pop_last) begin
                            if (r_loop_pend) begin
                                r_loop_pend <= 1'b0;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                ABORT: begin
                    if (r_outstanding == '0 && !r_arvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axi_arid    = 4'd0;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'(LOG_BPB);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = w_rready;
    assign m_axi_awvalid = 1'b0;
    assign m_axi_wvalid  = 1'b0;
    assign m_axi_bready  = 1'b1;

    assign m_axis_tdata  = w_fifo_dout[DATA_WIDTH-1:0];
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tlast  = w_tvalid && w_fifo_dout[DATA_WIDTH];
    assign busy          = (r_state == RUN) || (r_state == ABORT);
    assign play_done     = r_done;
    assign rd_err        = r_err;
    assign run_cycles    = r_run_cycles;
    assign beats_sent    = r_beats_sent;

endmodule
